regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameters: XLEN, default 64, data width; NREG, default 32, register count (power of two, >=2); NRD, default 2, read-port count; AW = log2(NREG), derived, not overridable.
REQ-002 SHALL have ports, one per line, in this order:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- raddr_i  in  NRD*AW  packed read addresses; port k at bits [k*AW +: AW]
- rdata_o  out  NRD*XLEN  packed read data
- rrdy_o  out  NRD  per-port operand ready (not pending)
- wen0_i / waddr0_i / wdata0_i  in  1/AW/XLEN  write-back port 0 (older)
- wen1_i / waddr1_i / wdata1_i  in  1/AW/XLEN  write-back port 1 (younger)
- iss_valid_i  in  1  issue request claiming a destination
- iss_rd_i  in  AW  destination register of the issue
- iss_ready_o  out  1  issue accepted this cycle
- flush_i  in  1  clear all pending claims
- busy_cnt_o  out  AW+1  number of busy registers

Function
REQ-003 Register 0 SHALL always read 0, ignore writes, and never become busy.
REQ-004 Read ports SHALL be combinational, zero latency: addr 0 -> 0; else write-port-1 match -> wdata1_i; else write-port-0 match -> wdata0_i; else array contents.
REQ-005 While rst_n is low, every rdata_o SHALL be 0.
REQ-006 Both write ports SHALL update the array on the same edge; same nonzero address on both -> port 1 data stored.
REQ-007 Each register SHALL carry one busy bit; busy[0] is constant 0.
REQ-008 Issue handshake: iss_ready_o = !flush_i AND (!busy[iss_rd_i] OR a write port writes iss_rd_i this cycle); accepted = iss_valid_i AND iss_ready_o.
REQ-009 iss_ready_o SHALL not depend on iss_valid_i.
REQ-010 Accepted issue with iss_rd_i != 0 SHALL set busy[iss_rd_i] at next edge; iss_rd_i = 0 is accepted with no state change.
REQ-011 A write with wen SHALL clear busy[waddr] at next edge; write to a non-busy register still updates data.
REQ-012 Same register set by issue and cleared by a write in one cycle -> busy ends set (set wins).
REQ-013 flush_i high SHALL clear all busy bits at next edge; writes in that cycle still update data.
REQ-014 rrdy_o[k] = 1 when addr is 0, or busy bit clear, or a write port targets that addr this cycle; else 0.
REQ-015 busy_cnt_o SHALL be registered, equal to the population count of busy bits after each edge, range 0..NREG-1.
REQ-016 All outputs SHALL be free of X for any input combination once reset has been applied.

Reset
REQ-017 rst_n low SHALL immediately clear all registers, all busy bits and busy_cnt_o, without waiting for clk.
REQ-018 Reset asserted mid-operation SHALL discard any pending issue or write in that cycle; first update after deassertion is at the first rising edge with rst_n high.
REQ-019 During reset iss_ready_o SHALL be 0 and rrdy_o SHALL be all 1.

Verification
REQ-020 Write x5=0x1234 via port 0, read port 1 addr 5 in the same cycle -> 0x1234 combinationally; next cycle from array -> 0x1234.
REQ-021 Both ports write x7 (port0 0xAA, port1 0xBB) -> same-cycle read 0xBB; stored value 0xBB.
REQ-022 Issue x3 -> busy_cnt_o=1, rrdy_o for x3 = 0; second issue x3 -> iss_ready_o=0; write x3 -> iss_ready_o=1, rrdy_o=1 that same cycle; next edge busy_cnt_o=0.
REQ-023 Issue x9 and write x9 in the same cycle while x9 busy -> x9 remains busy, busy_cnt_o unchanged.
REQ-024 Issue x1,x2,x4; then flush_i with iss_valid_i for x6 -> iss_ready_o=0, next edge busy_cnt_o=0, x6 not busy.
REQ-025 Write x0=0xFFFF and issue x0 -> reads of x0 return 0, busy_cnt_o unchanged; pulse rst_n low between edges -> all reads 0, busy_cnt_o 0 immediately.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write-through reads and a per-register busy scoreboard
// Two write-back ports (port 1 younger) and one issue port that claims destination registers.
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rrdy_o,
  input  logic                wen0_i,
  input  logic [AW-1:0]       waddr0_i,
  input  logic [XLEN-1:0]     wdata0_i,
  input  logic                wen1_i,
  input  logic [AW-1:0]       waddr1_i,
  input  logic [XLEN-1:0]     wdata1_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic                iss_ready_o,
  input  logic                flush_i,
  output logic [AW:0]         busy_cnt_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;
  logic            wr0;
  logic            wr1;
  logic            iss_hit_wr;
  logic            iss_take;

  assign wr0 = wen0_i && (waddr0_i != '0);
  assign wr1 = wen1_i && (waddr1_i != '0);

  // A write retiring the destination this cycle frees it for a new claim.
  assign iss_hit_wr  = (wen0_i && (waddr0_i == iss_rd_i)) || (wen1_i && (waddr1_i == iss_rd_i));
  assign iss_ready_o = rst_n && !flush_i && (!busy[iss_rd_i] || iss_hit_wr);
  assign iss_take    = iss_valid_i && iss_ready_o && (iss_rd_i != '0);

  always_comb begin
    busy_nxt = busy;
    if (wen0_i) busy_nxt[waddr0_i] = 1'b0;
    if (wen1_i) busy_nxt[waddr1_i] = 1'b0;
    if (iss_take) busy_nxt[iss_rd_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    rdata_o = '0;
    rrdy_o  = '1;
    a       = '0;
    if (rst_n) begin
      for (int k = 0; k < NRD; k++) begin
        a = raddr_i[k*AW +: AW];
        if (a == '0)
          rdata_o[k*XLEN +: XLEN] = '0;
        else if (wen1_i && (waddr1_i == a))
          rdata_o[k*XLEN +: XLEN] = wdata1_i;
        else if (wen0_i && (waddr0_i == a))
          rdata_o[k*XLEN +: XLEN] = wdata0_i;
        else
          rdata_o[k*XLEN +: XLEN] = regs[a];
        rrdy_o[k] = (a == '0) || !busy[a] ||
                    (wen0_i && (waddr0_i == a)) || (wen1_i && (waddr1_i == a));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      if (wr0) regs[waddr0_i] <= wdata0_i;
      if (wr1) regs[waddr1_i] <= wdata1_i;
      busy       <= busy_nxt;
      busy_cnt_o <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed scoreboard bench for regfile_sb
module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rrdy;
  logic                wen0, wen1;
  logic [AW-1:0]       waddr0, waddr1;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                flush;
  logic [AW:0]         busy_cnt;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr), .rdata_o(rdata), .rrdy_o(rrdy),
    .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_ready_o(iss_ready),
    .flush_i(flush), .busy_cnt_o(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [63:0] rd(input int k);
    return rdata[k*XLEN +: XLEN];
  endfunction

  task automatic idle();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    iss_valid = 0; iss_rd = '0; flush = 0;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    @(negedge clk); idle(); iss_valid = 1; iss_rd = r;
    #2 push("issue_ready", 1); chk(iss_ready);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle();
    raddr = {5'd5, 5'd5}; iss_valid = 1; iss_rd = 5'd3;
    #3;
    push("rst_rd0", 0);      chk(rd(0));
    push("rst_rd1", 0);      chk(rd(1));
    push("rst_rrdy", 2'b11); chk(rrdy);
    push("rst_issrdy", 0);   chk(iss_ready);
    push("rst_cnt", 0);      chk(busy_cnt);
    @(negedge clk); rst_n = 1; idle();

    // same-cycle bypass from port 0, then array read
    @(negedge clk); wen0 = 1; waddr0 = 5'd5; wdata0 = 64'h1234; raddr = {5'd5, 5'd0};
    #2 push("byp0_rd1", 64'h1234); chk(rd(1));
    push("byp0_rd0_x0", 0); chk(rd(0));
    @(negedge clk); idle(); raddr = {5'd5, 5'd5};
    #2 push("arr_x5_rd1", 64'h1234); chk(rd(1));
    push("arr_x5_rd0", 64'h1234); chk(rd(0));

    // both ports write x7, younger port wins
    @(negedge clk); wen0 = 1; waddr0 = 5'd7; wdata0 = 64'hAA;
    wen1 = 1; waddr1 = 5'd7; wdata1 = 64'hBB; raddr = {5'd5, 5'd7};
    #2 push("dual_byp", 64'hBB); chk(rd(0));
    @(negedge clk); idle();
    #2 push("dual_store", 64'hBB); chk(rd(0));

    // claim x3, block second claim, release by write
    issue(5'd3);
    @(negedge clk); idle(); raddr = {5'd5, 5'd3};
    #2 push("x3_cnt", 1); chk(busy_cnt);
    push("x3_rrdy", 0); chk(rrdy[0]);
    iss_valid = 1; iss_rd = 5'd3;
    #1 push("x3_reissue", 0); chk(iss_ready);
    @(negedge clk); idle(); iss_rd = 5'd3; wen0 = 1; waddr0 = 5'd3; wdata0 = 64'h33;
    #2 push("x3_wr_issrdy", 1); chk(iss_ready);
    push("x3_wr_rrdy", 1); chk(rrdy[0]);
    @(negedge clk); idle();
    #2 push("x3_cleared_cnt", 0); chk(busy_cnt);

    // set and clear of x9 in one cycle: set wins
    issue(5'd9);
    @(negedge clk); idle();
    #2 push("x9_cnt", 1); chk(busy_cnt);
    iss_valid = 1; iss_rd = 5'd9; wen1 = 1; waddr1 = 5'd9; wdata1 = 64'h99; raddr = {5'd9, 5'd9};
    #1 push("x9_issrdy", 1); chk(iss_ready);
    push("x9_byp", 64'h99); chk(rd(1));
    @(negedge clk); idle();
    #2 push("x9_cnt_kept", 1); chk(busy_cnt);
    push("x9_rrdy", 2'b00); chk(rrdy);
    push("x9_data", 64'h99); chk(rd(0));
    wen0 = 1; waddr0 = 5'd9; wdata0 = 64'h9A;
    @(negedge clk); idle();
    #2 push("x9_released", 0); chk(busy_cnt);

    // flush with a competing issue
    issue(5'd1); issue(5'd2); issue(5'd4);
    @(negedge clk); idle();
    #2 push("three_busy", 3); chk(busy_cnt);
    flush = 1; iss_valid = 1; iss_rd = 5'd6;
    #1 push("flush_issrdy", 0); chk(iss_ready);
    @(negedge clk); idle(); raddr = {5'd4, 5'd6};
    #2 push("flush_cnt", 0); chk(busy_cnt);
    push("flush_rrdy", 2'b11); chk(rrdy);

    // register 0 is inert
    @(negedge clk); wen0 = 1; waddr0 = 5'd0; wdata0 = 64'hFFFF;
    iss_valid = 1; iss_rd = 5'd0; raddr = {5'd0, 5'd0};
    #2 push("x0_byp", 0); chk(rd(0));
    push("x0_issrdy", 1); chk(iss_ready);
    @(negedge clk); idle();
    #2 push("x0_cnt", 0); chk(busy_cnt);
    push("x0_rd", 0); chk(rd(1));

    // top register, then asynchronous reset between edges
    issue(5'd31);
    @(negedge clk); idle(); raddr = {5'd31, 5'd5};
    #2 push("x31_cnt", 1); chk(busy_cnt);
    push("x31_rrdy", 2'b01); chk(rrdy);
    push("pre_rst_x5", 64'h1234); chk(rd(0));
    #1 rst_n = 0;
    #1 push("async_cnt", 0); chk(busy_cnt);
    push("async_rd0", 0); chk(rd(0));
    push("async_rrdy", 2'b11); chk(rrdy);
    push("async_issrdy", 0); chk(iss_ready);
    @(negedge clk); rst_n = 1;
    #2 push("post_rst_x5", 0); chk(rd(0));
    push("post_rst_cnt", 0); chk(busy_cnt);
    push("post_rst_rrdy", 2'b11); chk(rrdy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
